// File: rtl/spi_sfr_seq_pkg.sv
// Shared definitions for the spi_sfr_seq command sequencer: FSM state
// encoding, spi_ms register addresses, control-register bit positions and
// helpers that build the configuration bytes.
package spi_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG0,
    ST_CFG1,
    ST_CFG2,
    ST_SEL,
    ST_WAIT_TX,
    ST_LOAD,
    ST_POLL,
    ST_GAP,
    ST_RDRX,
    ST_HOLD,
    ST_DESEL
  } seq_state_e;

  // Core write addresses
  localparam logic [1:0] W_CTRL = 2'd0;
  localparam logic [1:0] W_AUX  = 2'd1;
  localparam logic [1:0] W_BR   = 2'd2;
  localparam logic [1:0] W_DATA = 2'd3;

  // Core read addresses
  localparam logic [2:0] R_DATA = 3'd3;
  localparam logic [2:0] R_STAT = 3'd5;

  // Status / control bit positions
  localparam int SPIF_BIT  = 7;
  localparam int CTRL_SPE  = 6;
  localparam int CTRL_MSTR = 4;
  localparam int CTRL_CPOL = 3;
  localparam int CTRL_CPHA = 2;

  // Fixed value written to the auxiliary register
  localparam logic [7:0] AUX_VAL = 8'h01;

  // Idle cycles spent with the slave released before returning to IDLE
  localparam int DESEL_IDLE = 2;

  // Control register: core enabled, master mode, chosen clock mode.
  function automatic logic [7:0] ctrl_byte(input logic cpol, input logic cpha);
    logic [7:0] b;
    b            = 8'h00;
    b[CTRL_SPE]  = 1'b1;
    b[CTRL_MSTR] = 1'b1;
    b[CTRL_CPOL] = cpol;
    b[CTRL_CPHA] = cpha;
    return b;
  endfunction

  // Baud register: {0, SPPR[2:0], 0, SPR[2:0]}.
  function automatic logic [7:0] baud_byte(input logic [5:0] br);
    return {1'b0, br[5:3], 1'b0, br[2:0]};
  endfunction

endpackage

// File: rtl/spi_sfr_seq.sv
// spi_sfr_seq: master-side command sequencer in front of spi_ms.
// Programs the core registers from a start-time configuration, keeps the
// selected slave low across a burst, runs one SPI frame per TX byte by
// writing the data register and polling SPIF, and returns each received
// byte on a valid/ready stream.
// Optional build macro SPI_SEQ_TIMEOUT_EN adds a TMO_W-bit poll timeout that
// aborts the burst and raises the sticky tmo_err flag; without it polling
// waits indefinitely and tmo_err is tied low.
module spi_sfr_seq
  import spi_seq_pkg::*;
#(
  parameter int unsigned SS_IDX   = 0,
  parameter int unsigned POLL_GAP = 2,
  parameter int unsigned TMO_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_cpol,
  input  logic       cfg_cpha,
  input  logic [5:0] cfg_br,
  input  logic       start,
  output logic       busy,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       tmo_err,
  output logic [1:0] sfraddr_w,
  output logic       sfrwe,
  output logic [7:0] spidata_o,
  output logic [2:0] sfraddr_r,
  input  logic [7:0] sfr_data_i,
  output logic [7:0] spssn_o
);

  // One small counter serves both the poll gap and the post-release idle time.
  localparam int unsigned CNT_MAX = (POLL_GAP > DESEL_IDLE) ? POLL_GAP : DESEL_IDLE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(POLL_GAP - 1);
  localparam logic [CNT_W-1:0] DESEL_END = CNT_W'(DESEL_IDLE);
  localparam logic [7:0] SEL_MASK = ~(8'h01 << SS_IDX);

  seq_state_e       state;
  logic [5:0]       br_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt;
  logic             tmo_hit;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - 1'b1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             polling;

  assign polling = (state == ST_POLL) || (state == ST_GAP);
  // Fires on the cycle in which the counter would reach all-ones.
  assign tmo_hit = polling && (tmo_cnt == TMO_LAST);

  // Poll timeout counter and sticky error flag; counter clears whenever polling ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (tmo_hit || !polling || (state == ST_POLL && sfr_data_i[SPIF_BIT])) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == ST_IDLE && start) begin
        tmo_err <= 1'b0;
      end else if (tmo_hit) begin
        tmo_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  // Burst sequencer: every output is registered and reflects the state being entered.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // still releases spssn_o on the very edge that samples rst.
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      sfrwe     <= 1'b0;
      sfraddr_w <= 2'd0;
      spidata_o <= 8'h00;
      sfraddr_r <= 3'd0;
      spssn_o   <= 8'hFF;
      br_q      <= 6'd0;
      last_q    <= 1'b0;
      cnt       <= '0;
    end else begin
      // NOTE: state updates are non-blocking so every branch sees the
      // pre-edge values; sfrwe defaults low so a write is a single pulse.
      sfrwe <= 1'b0;
      if (tmo_hit) begin
        tx_ready <= 1'b0;
        spssn_o  <= 8'hFF;
        cnt      <= '0;
        state    <= ST_DESEL;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              busy      <= 1'b1;
              br_q      <= cfg_br;
              sfrwe     <= 1'b1;
              sfraddr_w <= W_CTRL;
              spidata_o <= ctrl_byte(cfg_cpol, cfg_cpha);
              state     <= ST_CFG0;
            end
          end
          ST_CFG0: begin
            sfrwe     <= 1'b1;
            sfraddr_w <= W_AUX;
            spidata_o <= AUX_VAL;
            state     <= ST_CFG1;
          end
          ST_CFG1: begin
            sfrwe     <= 1'b1;
            sfraddr_w <= W_BR;
            spidata_o <= baud_byte(br_q);
            state     <= ST_CFG2;
          end
          ST_CFG2: begin
            spssn_o <= SEL_MASK;
            state   <= ST_SEL;
          end
          ST_SEL: begin
            tx_ready <= 1'b1;
            state    <= ST_WAIT_TX;
          end
          ST_WAIT_TX: begin
            if (tx_valid) begin
              tx_ready  <= 1'b0;
              last_q    <= tx_last;
              sfrwe     <= 1'b1;
              sfraddr_w <= W_DATA;
              spidata_o <= tx_data;
              state     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            sfraddr_r <= R_STAT;
            state     <= ST_POLL;
          end
          ST_POLL: begin
            if (sfr_data_i[SPIF_BIT]) begin
              sfraddr_r <= R_DATA;
              state     <= ST_RDRX;
            end else begin
              cnt   <= '0;
              state <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (cnt == GAP_END) begin
              state <= ST_POLL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RDRX: begin
            rx_data  <= sfr_data_i;
            rx_valid <= 1'b1;
            state    <= ST_HOLD;
          end
          ST_HOLD: begin
            if (rx_ready) begin
              rx_valid <= 1'b0;
              if (last_q) begin
                spssn_o <= 8'hFF;
                cnt     <= '0;
                state   <= ST_DESEL;
              end else begin
                tx_ready <= 1'b1;
                state    <= ST_WAIT_TX;
              end
            end
          end
          ST_DESEL: begin
            if (cnt == DESEL_END) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sfr_seq.sv
// Self-checking bench for spi_sfr_seq. A behavioural spi_ms model answers
// the SFR port (SPIF after a random delay, returned byte = sent byte ^ key),
// a negedge process checks every core write, the slave select and the RX
// stream against queues filled from the register-map rules.
module tb_spi_sfr_seq;

  localparam int unsigned SS_IDX   = 0;
  localparam int unsigned POLL_GAP = 2;
  localparam int unsigned TMO_W    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_cpol, cfg_cpha;
  logic [5:0] cfg_br;
  logic       start, busy;
  logic       tx_valid, tx_last, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       tmo_err;
  logic [1:0] sfraddr_w;
  logic       sfrwe;
  logic [7:0] spidata_o;
  logic [2:0] sfraddr_r;
  logic [7:0] sfr_data_i;
  logic [7:0] spssn_o;

  spi_sfr_seq #(.SS_IDX(SS_IDX), .POLL_GAP(POLL_GAP), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_br(cfg_br),
    .start(start), .busy(busy), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tmo_err(tmo_err), .sfraddr_w(sfraddr_w), .sfrwe(sfrwe),
    .spidata_o(spidata_o), .sfraddr_r(sfraddr_r), .sfr_data_i(sfr_data_i),
    .spssn_o(spssn_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [7:0] data; logic last; } rx_t;

  wr_t        exp_wr[$];
  rx_t        exp_rx[$];
  logic [7:0] burst_q[$];

  int checks = 0;
  int errors = 0;

  // Core / checker model state
  bit         chk_en, sp_chk, no_spif;
  bit         spif, stat_seen, sel_exp, arm_sel, arm_desel, rx_pend;
  int         spif_cd, hold_n, rx_wait;
  logic [7:0] rxbuf, pend_byte, key, rx_hold_data, sel_val;

  assign sfr_data_i = (sfraddr_r == 3'd5) ? {spif, 7'b0} :
                      (sfraddr_r == 3'd3) ? rxbuf : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic void push_wr(input logic [1:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endfunction

  // Expected configuration writes, derived arithmetically from the register map.
  function automatic void push_cfg(input logic cpol, input logic cpha, input logic [5:0] br);
    logic [7:0] ctrl;
    int         b;
    ctrl = 8'h50;
    if (cpol) ctrl = ctrl + 8'h08;
    if (cpha) ctrl = ctrl + 8'h04;
    b = int'(br);
    push_wr(2'd0, ctrl);
    push_wr(2'd1, 8'h01);
    push_wr(2'd2, 8'((b / 8) * 16 + (b % 8)));
  endfunction

  function automatic void model_clear();
    spif = 0; stat_seen = 0; spif_cd = 0; sel_exp = 0; arm_sel = 0;
    arm_desel = 0; rx_pend = 0; hold_n = 0;
    exp_wr.delete();
    exp_rx.delete();
  endfunction

  // Core model and scoreboard, evaluated mid-cycle.
  initial begin : core_and_checker
    wr_t w;
    rx_t r;
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        rx_ready = 1'b0;
      end else begin
        if (spif_cd > 0) begin
          spif_cd--;
          if (spif_cd == 0) begin
            spif  = 1'b1;
            rxbuf = pend_byte ^ key;
          end
        end
        if (sfraddr_r == 3'd5 && spif) stat_seen = 1'b1;
        else if (sfraddr_r == 3'd3 && stat_seen) begin
          spif = 1'b0;
          stat_seen = 1'b0;
        end

        if (arm_sel)   begin sel_exp = 1'b1; arm_sel = 1'b0; end
        if (arm_desel) begin sel_exp = 1'b0; arm_desel = 1'b0; end
        if (sp_chk) check("spssn", spssn_o, sel_exp ? sel_val : 8'hFF);

        if (rx_valid) begin
          if (!rx_pend) begin
            rx_pend = 1'b1;
            rx_hold_data = rx_data;
            rx_wait = (hold_n > 0) ? hold_n : int'($urandom_range(0, 3));
            hold_n = 0;
          end else begin
            check("rx_stable", rx_data, rx_hold_data);
          end
          if (rx_wait == 0) begin
            rx_ready = 1'b1;
            rx_pend  = 1'b0;
            check("rx_expected", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) begin
              r = exp_rx.pop_front();
              check("rx_data", rx_data, r.data);
              if (r.last) arm_desel = 1'b1;
            end
          end else begin
            rx_ready = 1'b0;
            rx_wait--;
          end
        end else begin
          rx_ready = 1'b0;
          rx_pend  = 1'b0;
        end

        if (sfrwe) begin
          check("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("wr_addr", sfraddr_w, w.addr);
            check("wr_data", spidata_o, w.data);
          end
          if (sfraddr_w == 2'd2) arm_sel = 1'b1;
          if (sfraddr_w == 2'd3) begin
            check("w3_spif_clear", spif || (spif_cd > 0) || rx_valid, 0);
            pend_byte = spidata_o;
            if (!no_spif) spif_cd = int'($urandom_range(1, 12));
          end
        end
      end
    end
  end

  task automatic do_start(input logic cpol, input logic cpha, input logic [5:0] br);
    @(negedge clk);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_br = br; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_set", busy, 1);
    check("first_wr_latency", sfrwe, 1);
    check("tmo_err_cleared", tmo_err, 0);
    cfg_cpol = 1'($urandom_range(0, 1));
    cfg_cpha = 1'($urandom_range(0, 1));
    cfg_br   = 6'($urandom_range(0, 63));
    @(negedge clk);
    start = 1'b1;  // arrives while busy: must be ignored
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    tx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    tx_valid = 1'b1; tx_data = d; tx_last = last;
    t = 0;
    while (tx_ready !== 1'b1 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", t < 600, 1);
    @(negedge clk);
    check("tx_ready_drop", tx_ready, 0);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("burst_done", busy, 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rx_queue_drained", exp_rx.size(), 0);
  endtask

  task automatic run_burst(input logic cpol, input logic cpha, input logic [5:0] br,
                           input int hold, input logic [7:0] k);
    rx_t r;
    key = k;
    hold_n = hold;
    push_cfg(cpol, cpha, br);
    foreach (burst_q[i]) begin
      push_wr(2'd3, burst_q[i]);
      r.data = burst_q[i] ^ k;
      r.last = (i == burst_q.size() - 1);
      exp_rx.push_back(r);
    end
    do_start(cpol, cpha, br);
    foreach (burst_q[i]) send_byte(burst_q[i], i == burst_q.size() - 1);
    wait_idle();
  endtask

  initial begin : stimulus
    int t;
    sel_val = ~(8'h01 << SS_IDX);
    rst = 1'b1; start = 1'b0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_br = 6'd0;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    chk_en = 0; sp_chk = 1; no_spif = 0; key = 8'h00; rxbuf = 8'h00; pend_byte = 8'h00;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tmo_err", tmo_err, 0);
    check("rst_sfrwe", sfrwe, 0);
    check("rst_sfraddr_w", sfraddr_w, 0);
    check("rst_sfraddr_r", sfraddr_r, 0);
    check("rst_spidata", spidata_o, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_spssn", spssn_o, 8'hFF);
    rst = 1'b0;
    chk_en = 1;

    // TX stream offered while idle is not accepted and starts nothing
    tx_valid = 1'b1; tx_data = 8'h99; tx_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("tx_ready_idle", tx_ready, 0);
    end
    tx_valid = 1'b0;

    // Loopback burst A5, 3C, FF in mode 0
    burst_q.delete();
    burst_q.push_back(8'hA5); burst_q.push_back(8'h3C); burst_q.push_back(8'hFF);
    run_burst(1'b0, 1'b0, 6'h03, 0, 8'h00);

    // Mode sweep with single-byte bursts
    burst_q.delete(); burst_q.push_back(8'h5A);
    run_burst(1'b0, 1'b1, 6'h3F, 0, 8'h00);
    run_burst(1'b1, 1'b0, 6'h3F, 0, 8'h00);
    run_burst(1'b1, 1'b1, 6'h3F, 0, 8'h00);

    // Receiver stalls 20 cycles on the first byte
    burst_q.delete(); burst_q.push_back(8'h81); burst_q.push_back(8'h42);
    run_burst(1'b0, 1'b0, 6'h12, 20, 8'h00);

    // Randomized bursts with a non-trivial returned byte
    for (int k = 0; k < 5; k++) begin
      burst_q.delete();
      repeat ($urandom_range(1, 5)) burst_q.push_back(8'($urandom_range(0, 255)));
      run_burst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 63)), 0, 8'($urandom_range(0, 255)));
    end

    // Reset while polling
    chk_en = 0; no_spif = 1;
    @(negedge clk);
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_br = 6'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (tx_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    check("rstpoll_tx_ready", tx_ready, 1);
    tx_valid = 1'b1; tx_data = 8'h11; tx_last = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while (sfraddr_r !== 3'd5 && t < 100) begin @(negedge clk); t++; end
    check("rstpoll_in_poll", sfraddr_r, 5);
    check("rstpoll_selected", spssn_o, sel_val);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstpoll_spssn", spssn_o, 8'hFF);
    check("rstpoll_busy", busy, 0);
    check("rstpoll_sfrwe", sfrwe, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    no_spif = 0;
    chk_en = 1;

    // Recovery after reset
    burst_q.delete(); burst_q.push_back(8'hC3); burst_q.push_back(8'h0F);
    run_burst(1'b1, 1'b0, 6'h2A, 0, 8'h5A);

`ifdef SPI_SEQ_TIMEOUT_EN
    // SPIF never rises: the burst aborts and flags a timeout
    no_spif = 1; sp_chk = 0;
    push_cfg(1'b0, 1'b0, 6'h05);
    push_wr(2'd3, 8'h77);
    do_start(1'b0, 1'b0, 6'h05);
    send_byte(8'h77, 1'b1);
    wait_idle();
    check("tmo_err_set", tmo_err, 1);
    check("tmo_spssn", spssn_o, 8'hFF);
    check("tmo_tx_ready", tx_ready, 0);
    model_clear();
    no_spif = 0; sp_chk = 1;
    burst_q.delete(); burst_q.push_back(8'h3E);
    run_burst(1'b0, 1'b1, 6'h07, 0, 8'h00);
`endif
    check("tmo_err_final", tmo_err, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
